ex_mem_pipe_reg: RTL

- Parametrised EX/MEM pipeline register between the Execute and Memory stages.
- Generalises the fixed 64-bit EX/MEM latch with configurable datapath, register-address and control-bundle widths.
- Adds a valid/ready handshake so either stage can stall without losing data, and a 2-entry skid buffer that sustains one transfer per cycle.
- Flush converts every held entry into a bubble: valid low, control zero.

---
 rtl/ex_mem_pipe_reg.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready handshake and a two-entry skid
// buffer. The head entry drives the MEM-side outputs; the skid entry catches
// one extra instruction when MEM stalls. Flush and reset turn everything into
// bubbles.
module ex_mem_pipe_reg #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CTRL_W  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  // EX side
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_adder,
  input  logic [XLEN-1:0]    in_alu,
  input  logic               in_zero,
  input  logic [XLEN-1:0]    in_wdata,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [CTRL_W-1:0]  in_ctrl,
  // MEM side
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_adder,
  output logic [XLEN-1:0]    out_alu,
  output logic [XLEN-1:0]    out_wdata,
  output logic               out_zero,
  output logic [RADDR_W-1:0] out_rd,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [1:0]         occupancy
);

  // One pipeline slot; ctrl is last so a bubble only needs that field cleared.
  typedef struct packed {
    logic [XLEN-1:0]    adder;
    logic [XLEN-1:0]    alu;
    logic               zero;
    logic [XLEN-1:0]    wdata;
    logic [RADDR_W-1:0] rd;
    logic [CTRL_W-1:0]  ctrl;
  } entry_t;

  // State value equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;

  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  // Pack the incoming EX fields into one slot.
  always_comb begin
    in_entry.adder = in_adder;
    in_entry.alu   = in_alu;
    in_entry.zero  = in_zero;
    in_entry.wdata = in_wdata;
    in_entry.rd    = in_rd;
    in_entry.ctrl  = in_ctrl;
  end

  // Next-state and slot updates; main_q.ctrl is kept at zero whenever the head is empty.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_fire  = in_valid & in_ready_q;
    out_fire = out_valid_q & out_ready;

    if (flush) begin
      state_d     = ST_EMPTY;
      main_d.ctrl = '0;
      skid_d.ctrl = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            skid_d  = in_entry;
            state_d = ST_FULL;
          end else if (out_fire) begin
            main_d.ctrl = '0;
            state_d     = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // No input is accepted here, so the skid simply promotes to head.
          if (out_fire) begin
            main_d      = skid_q;
            skid_d.ctrl = '0;
            state_d     = ST_ONE;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_d.ctrl = '0;
          skid_d.ctrl = '0;
        end
      endcase
    end

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State, slot and handshake registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_adder = main_q.adder;
  assign out_alu   = main_q.alu;
  assign out_wdata = main_q.wdata;
  assign out_zero  = main_q.zero;
  assign out_rd    = main_q.rd;
  assign out_ctrl  = main_q.ctrl;
  assign occupancy = state_q;

endmodule
